uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualify at mid-bit, MSB-first data, optional parity, stop check.
// Define UART_RX_PARITY_EN to add the parity bit and the PARITY state (11-bit frame instead of 10).
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       bclk_rx,
    input  logic       p_sel,
    output logic [7:0] d_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            valid_q, valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            sync1_q, sync2_q;
    logic            perr_q, perr_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        d_out_d      = d_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        perr_d       = perr_q;
        if (bclk_rx) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF) begin
                        // A start bit that is high again at mid-bit was only a glitch.
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        shreg_d = {shreg_q[6:0], rx_s};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        perr_d  = rx_s != (p_sel ? ^shreg_q : ~^shreg_q);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_d        = '0;
                        valid_d      = 1'b1;
                        d_out_d      = shreg_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ~rx_s;
                        // A low stop bit means break: wait for the line to recover first.
                        state_d      = rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            d_out_q      <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            perr_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            d_out_q      <= d_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            perr_q       <= perr_d;
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
        end
    end

    assign d_out     = d_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    logic unused_p_sel;
    assign unused_p_sel = p_sel;
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame bench for uart_rx; expectations come from a frame-level model of the serial line.
module tb_uart_rx;
    localparam int OS  = 16;
    localparam int DIV = 2;
    localparam int BT  = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int FB = PEN ? 11 : 10;

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, bclk_rx = 1'b0, p_sel = 1'b0;
    logic [7:0] d_out;
    logic       valid, parity_err, frame_err;

    int checks = 0, failures = 0;
    int divc = 0;
    int cyc = 0;
    int vcount = 0, vt_last = 0, vt_prev = 0;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .rx(rx), .bclk_rx(bclk_rx), .p_sel(p_sel),
        .d_out(d_out), .valid(valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        divc    = (divc + 1) % DIV;
        bclk_rx = (divc == 0);
        if (valid) begin
            vcount  = vcount + 1;
            vt_prev = vt_last;
            vt_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Parity bit a well-behaved transmitter sends: even/odd total count of ones.
    function automatic logic good_par(input logic [7:0] d, input logic ps);
        int ones;
        ones = $countones(d);
        return ps ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        if (PEN) send_bit(pbit);
        send_bit(stopb);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] d, input logic pbit);
        int v0;
        v0 = vcount;
        send_frame(d, pbit, 1'b1);
        chk({tag, "_vcnt"}, vcount - v0, 1);
        chk({tag, "_dout"}, d_out, d);
        chk({tag, "_perr"}, parity_err, PEN && (pbit != good_par(d, p_sel)));
        chk({tag, "_ferr"}, frame_err, 0);
    endtask

    initial begin
        int v0;
        logic [7:0] d, d2;
        logic pb;

        repeat (5) @(negedge clk);
        chk("rst_dout", d_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b0;
        repeat (2 * BT) @(negedge clk);

        p_sel = 1'b0;
        frame_check("a5_ok", 8'hA5, 1'b1);
        frame_check("a5_badpar", 8'hA5, 1'b0);

        for (int n = 0; n < 10; n++) begin
            d     = 8'($urandom);
            p_sel = 1'($urandom);
            pb    = good_par(d, p_sel);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            frame_check("rand", d, pb);
            repeat ($urandom_range(0, 2 * BT)) @(negedge clk);
        end

        // Break: low stop bit, then line held low for a long time.
        p_sel = 1'b1;
        v0 = vcount;
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("brk_vcnt", vcount - v0, 1);
        chk("brk_dout", d_out, 8'h3C);
        chk("brk_ferr", frame_err, 1);
        chk("brk_perr", parity_err, 0);
        repeat (40 * BT) @(negedge clk);
        chk("brk_quiet", vcount - v0, 1);
        rx = 1'b1;
        repeat (2 * BT) @(negedge clk);
        chk("brk_recover", vcount - v0, 1);
        frame_check("after_brk", 8'h55, good_par(8'h55, p_sel));
        repeat (3 * BT) @(negedge clk);
        chk("hold_dout", d_out, 8'h55);

        // Short low glitch on an idle line.
        v0 = vcount;
        rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BT) @(negedge clk);
        chk("glitch_vcnt", vcount - v0, 0);
        frame_check("after_glitch", 8'h55, good_par(8'h55, p_sel));

        // Reset in the middle of the 4th data bit of 0xFF.
        v0 = vcount;
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        rx = 1'b1;
        repeat (BT / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_dout", d_out, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_perr", parity_err, 0);
        chk("mid_rst_ferr", frame_err, 0);
        reset = 1'b0;
        repeat (12 * BT) @(negedge clk);
        chk("mid_rst_vcnt", vcount - v0, 0);
        frame_check("after_rst", 8'h81, good_par(8'h81, p_sel));

        // Back-to-back frames with no idle gap.
        p_sel = 1'($urandom);
        d  = 8'h0F;
        d2 = 8'($urandom);
        v0 = vcount;
        send_frame(d, good_par(d, p_sel), 1'b1);
        chk("b2b_first", d_out, d);
        send_frame(d2, good_par(d2, p_sel), 1'b1);
        chk("b2b_vcnt", vcount - v0, 2);
        chk("b2b_dout", d_out, d2);
        chk("b2b_perr", parity_err, 0);
        chk("b2b_spacing", vt_last - vt_prev, FB * BT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
